// File: rtl/note_lane_scroller.sv
// -----------------------------------------------------------------------------
// note_lane_scroller
//
// Owns the falling notes of one guitar lane. Notes are spawned at y = 0,
// advanced by SPEED pixels once per video frame, and retired either by the
// scoring logic (hit_pop) or automatically once the head note reaches
// SCREEN_H (miss). The oldest note's y is presented to the downstream
// intersect comparator, and the renderer can read any live note by index.
//
// Optional feature macro: MISS_COUNTER_EN
//   defined   -> miss_count is a saturating 16-bit count of miss pulses
//   undefined -> miss_count is tied to 0
//
// Parameters
//   SLOTS     note buffer depth (power of two, >= 2)
//   SCREEN_H  y value at which a note is off-screen
//   SPEED     pixels added to every live note per frame (1..15)
//
// Ports
//   clock, resetn             clock, asynchronous active-low reset
//   frame_tick                one-cycle pulse per video frame
//   spawn_valid/spawn_ready   new-note handshake from the chart sequencer
//   hit_pop/hit_ready         head retirement handshake from scoring
//   head_valid, head_y        oldest note (head_y = 0 when empty)
//   rd_idx, rd_valid, rd_y    render read port, index counted from head
//   miss                      one-cycle pulse per auto-retired note
//   count                     number of live notes
//   tick_overrun              sticky, set when a frame_tick is dropped
//   miss_count                saturating miss counter (see macro above)
// -----------------------------------------------------------------------------
module note_lane_scroller #(
  parameter int SLOTS    = 8,
  parameter int SCREEN_H = 480,
  parameter int SPEED    = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     frame_tick,
  input  logic                     spawn_valid,
  output logic                     spawn_ready,
  input  logic                     hit_pop,
  output logic                     hit_ready,
  output logic                     head_valid,
  output logic [31:0]              head_y,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [31:0]              rd_y,
  output logic                     miss,
  output logic [$clog2(SLOTS):0]   count,
  output logic                     tick_overrun,
  output logic [15:0]              miss_count
);

  localparam int IW = $clog2(SLOTS);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   head_q, tail_q, idx_q;
  logic [CW-1:0]   count_q;
  logic            pending_q, overrun_q, miss_q;
  logic [9:0]      y_mem [SLOTS];

  // Control strobes produced by the FSM decode.
  logic            spawn_fire, pop_fire, retire, sweep_en;

  // Head / sweep / render-path helpers.
  logic [9:0]      head_slot_y;
  logic            head_over;
  logic [IW-1:0]   sweep_off;
  logic            sweep_live;
  logic [10:0]     sweep_sum;
  logic [9:0]      sweep_y;
  logic [IW-1:0]   rd_ptr;

  assign head_slot_y = y_mem[head_q];
  assign head_over   = ({22'd0, head_slot_y} >= 32'(SCREEN_H));

  // A physical slot is live when its distance from head is below count;
  // count == SLOTS makes every slot live.
  assign sweep_off  = idx_q - head_q;
  assign sweep_live = ({1'b0, sweep_off} < count_q);
  assign sweep_sum  = {1'b0, y_mem[idx_q]} + 11'(SPEED);
  assign sweep_y    = sweep_sum[10] ? 10'h3FF : sweep_sum[9:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first so that no path
  // through the case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    spawn_ready = 1'b0;
    hit_ready   = 1'b0;
    spawn_fire  = 1'b0;
    pop_fire    = 1'b0;
    retire      = 1'b0;
    sweep_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        spawn_ready = (count_q < CW'(SLOTS));
        hit_ready   = (count_q != '0);
        spawn_fire  = spawn_valid & spawn_ready;
        pop_fire    = hit_pop & hit_ready;
        if (frame_tick || pending_q) state_d = SWEEP;
      end
      SWEEP: begin
        sweep_en = 1'b1;
        if (idx_q == IW'(SLOTS - 1)) state_d = CHECK;
      end
      CHECK: begin
        // Retire one off-screen head per cycle until the head is on-screen.
        if ((count_q != '0) && head_over) retire = 1'b1;
        else                              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, sweep index, tick bookkeeping, miss pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      if (spawn_fire)          tail_q <= tail_q + 1'b1;
      if (pop_fire || retire)  head_q <= head_q + 1'b1;

      unique case ({spawn_fire, pop_fire | retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Index runs 0..SLOTS-1 during SWEEP and wraps back to 0 naturally.
      if (state_q == SWEEP) idx_q <= idx_q + 1'b1;
      else                  idx_q <= '0;

      if (state_q == IDLE) begin
        // Entering SWEEP consumes one tick; a fresh tick arriving together
        // with a pending one stays queued rather than being lost.
        pending_q <= pending_q & frame_tick;
      end else if (frame_tick) begin
        if (pending_q) overrun_q <= 1'b1;
        else           pending_q <= 1'b1;
      end

      miss_q <= retire;
    end
  end

  // ---------------------------------------------------------------------------
  // Note y storage
  // ---------------------------------------------------------------------------
  // NOTE: the y store is reset explicitly because a reset mid-SWEEP must leave
  // no partially advanced slot behind; this keeps it in flops, not RAM.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SLOTS; s++) y_mem[s] <= '0;
    end else begin
      if (spawn_fire)              y_mem[tail_q] <= '0;
      if (sweep_en && sweep_live)  y_mem[idx_q]  <= sweep_y;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_ptr       = head_q + rd_idx;
  assign rd_valid     = ({1'b0, rd_idx} < count_q);
  assign rd_y         = rd_valid ? {22'd0, y_mem[rd_ptr]} : 32'd0;
  assign head_valid   = (count_q != '0);
  assign head_y       = head_valid ? {22'd0, head_slot_y} : 32'd0;
  assign count        = count_q;
  assign miss         = miss_q;
  assign tick_overrun = overrun_q;

`ifdef MISS_COUNTER_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                              miss_cnt_q <= '0;
    else if (miss_q && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 1'b1;
  end

  assign miss_count = miss_cnt_q;
`else
  assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_note_lane_scroller.sv
// -----------------------------------------------------------------------------
// tb_note_lane_scroller
//
// Directed bench for note_lane_scroller with default parameters (SLOTS=8,
// SCREEN_H=480, SPEED=2). Inputs are driven and outputs sampled on the falling
// clock edge; "N(t+k)" in the comments is the falling edge k rising edges
// after the rising edge t that sampled the step's frame_tick.
// -----------------------------------------------------------------------------
module tb_note_lane_scroller;

  localparam int SLOTS = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic        frame_tick;
  logic        spawn_valid;
  logic        spawn_ready;
  logic        hit_pop;
  logic        hit_ready;
  logic        head_valid;
  logic [31:0] head_y;
  logic [2:0]  rd_idx;
  logic        rd_valid;
  logic [31:0] rd_y;
  logic        miss;
  logic [3:0]  count;
  logic        tick_overrun;
  logic [15:0] miss_count;

  int vecs = 0;
  int errs = 0;

  note_lane_scroller #(
    .SLOTS    (SLOTS),
    .SCREEN_H (480),
    .SPEED    (2)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .hit_pop      (hit_pop),
    .hit_ready    (hit_ready),
    .head_valid   (head_valid),
    .head_y       (head_y),
    .rd_idx       (rd_idx),
    .rd_valid     (rd_valid),
    .rd_y         (rd_y),
    .miss         (miss),
    .count        (count),
    .tick_overrun (tick_overrun),
    .miss_count   (miss_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse frame_tick for one rising edge; returns at N(t).
  task automatic frame_pulse();
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_miss_count;
`ifdef MISS_COUNTER_EN
    exp_miss_count = 16'd1;
`else
    exp_miss_count = 16'd0;
`endif

    resetn      = 1'b0;
    frame_tick  = 1'b0;
    spawn_valid = 1'b0;
    hit_pop     = 1'b0;
    rd_idx      = '0;
    repeat (3) @(negedge clock);

    // ---- reset state -------------------------------------------------------
    check("rst_spawn_ready", 32'(spawn_ready), 32'd1);
    check("rst_hit_ready",   32'(hit_ready),   32'd0);
    check("rst_head_valid",  32'(head_valid),  32'd0);
    check("rst_head_y",      head_y,           32'd0);
    check("rst_count",       32'(count),       32'd0);
    check("rst_miss",        32'(miss),        32'd0);
    check("rst_overrun",     32'(tick_overrun), 32'd0);
    check("rst_rd_valid",    32'(rd_valid),    32'd0);
    check("rst_miss_count",  32'(miss_count),  32'd0);
    resetn = 1'b1;
    @(negedge clock);
    check("rel_spawn_ready", 32'(spawn_ready), 32'd1);

    // ---- one note, three frames: y = 0, 2, 4, 6 ---------------------------
    spawn_valid = 1'b1;
    @(negedge clock);
    spawn_valid = 1'b0;
    check("sp1_count",      32'(count),      32'd1);
    check("sp1_head_valid", 32'(head_valid), 32'd1);
    check("sp1_head_y",     head_y,          32'd0);
    check("sp1_hit_ready",  32'(hit_ready),  32'd1);

    for (int k = 1; k <= 3; k++) begin
      frame_pulse();                               // N(t), in SWEEP
      check("sweep_spawn_ready", 32'(spawn_ready), 32'd0);
      check("sweep_hit_ready",   32'(hit_ready),   32'd0);
      hit_pop = 1'b1;                              // must be ignored
      @(negedge clock);                            // N(t+1)
      hit_pop = 1'b0;
      check("sweep_pop_count", 32'(count), 32'd1);
      repeat (7) @(negedge clock);                 // N(t+8), in CHECK
      check("check_hit_ready", 32'(hit_ready), 32'd0);
      @(negedge clock);                            // N(t+9), back in IDLE
      check("idle_hit_ready", 32'(hit_ready), 32'd1);
      check("frame_head_y",   head_y,         32'(2 * k));
      repeat (10) @(negedge clock);
    end

    // ---- fill, full, spawn+pop --------------------------------------------
    spawn_valid = 1'b1;
    @(negedge clock);
    spawn_valid = 1'b0;
    frame_pulse();
    repeat (9) @(negedge clock);                   // N(t+9)
    rd_idx = 3'd1;
    #1;
    check("two_head_y",   head_y,         32'd8);
    check("two_rd_valid", 32'(rd_valid),  32'd1);
    check("two_rd_y",     rd_y,           32'd2);

    spawn_valid = 1'b1;
    repeat (6) @(negedge clock);
    check("full_count",       32'(count),       32'd8);
    check("full_spawn_ready", 32'(spawn_ready), 32'd0);
    @(negedge clock);                              // 9th spawn attempt
    spawn_valid = 1'b0;
    check("ninth_count", 32'(count), 32'd8);
    rd_idx = 3'd7;
    #1;
    check("full_rd7_valid", 32'(rd_valid), 32'd1);
    check("full_rd7_y",     rd_y,          32'd0);

    hit_pop = 1'b1;
    @(negedge clock);
    hit_pop = 1'b0;
    check("pop_count",  32'(count), 32'd7);
    check("pop_head_y", head_y,     32'd2);

    spawn_valid = 1'b1;
    hit_pop     = 1'b1;
    @(negedge clock);
    spawn_valid = 1'b0;
    hit_pop     = 1'b0;
    check("both_count",    32'(count),    32'd7);
    check("both_head_y",   head_y,        32'd0);
    check("both_rd7_valid", 32'(rd_valid), 32'd0);
    check("both_rd7_y",    rd_y,          32'd0);

    hit_pop = 1'b1;
    repeat (7) @(negedge clock);
    hit_pop = 1'b0;
    check("drain_count",      32'(count),      32'd0);
    check("drain_head_valid", 32'(head_valid), 32'd0);
    check("drain_head_y",     head_y,          32'd0);
    check("drain_hit_ready",  32'(hit_ready),  32'd0);

    hit_pop = 1'b1;                                // pop when empty
    @(negedge clock);
    hit_pop = 1'b0;
    check("empty_pop_count",  32'(count),     32'd0);
    check("empty_pop_hready", 32'(hit_ready), 32'd0);

    // ---- scroll off the bottom: 240 frames ---------------------------------
    spawn_valid = 1'b1;
    @(negedge clock);
    spawn_valid = 1'b0;
    for (int k = 1; k <= 239; k++) begin
      frame_pulse();
      repeat (11) @(negedge clock);
    end
    check("f239_head_y", head_y,      32'd478);
    check("f239_count",  32'(count),  32'd1);
    frame_pulse();                                 // tick 240, N(t)
    repeat (8) @(negedge clock);                   // N(t+8)
    check("f240_pre_miss",   32'(miss),  32'd0);
    check("f240_pre_head_y", head_y,     32'd480);
    check("f240_pre_count",  32'(count), 32'd1);
    @(negedge clock);                              // N(t+9)
    check("f240_miss",       32'(miss),       32'd1);
    check("f240_count",      32'(count),      32'd0);
    check("f240_head_valid", 32'(head_valid), 32'd0);
    @(negedge clock);                              // N(t+10)
    check("f240_miss_end",    32'(miss),        32'd0);
    check("f240_spawn_ready", 32'(spawn_ready), 32'd1);
    check("f240_miss_count",  32'(miss_count),  32'(exp_miss_count));

    // ---- two extra ticks during one SWEEP ----------------------------------
    frame_pulse();                                 // N(t)
    @(negedge clock);                              // N(t+1)
    frame_tick = 1'b1;
    @(negedge clock);                              // N(t+2), now pending
    frame_tick = 1'b0;
    check("pend_overrun", 32'(tick_overrun), 32'd0);
    frame_tick = 1'b1;
    @(negedge clock);                              // N(t+3), dropped
    frame_tick = 1'b0;
    check("drop_overrun", 32'(tick_overrun), 32'd1);
    repeat (6) @(negedge clock);                   // N(t+9), IDLE
    check("pend_idle", 32'(spawn_ready), 32'd1);
    @(negedge clock);                              // N(t+10), pending sweep
    check("pend_sweep", 32'(spawn_ready), 32'd0);
    repeat (10) @(negedge clock);                  // N(t+20)
    check("pend_done", 32'(spawn_ready), 32'd1);
    @(negedge clock);
    check("pend_once", 32'(spawn_ready), 32'd1);
    check("overrun_sticky", 32'(tick_overrun), 32'd1);

    // ---- reset mid-SWEEP ---------------------------------------------------
    spawn_valid = 1'b1;
    @(negedge clock);
    spawn_valid = 1'b0;
    frame_pulse();
    repeat (2) @(negedge clock);                   // N(t+2), mid-SWEEP
    #2 resetn = 1'b0;
    #1;
    check("mrst_count",       32'(count),        32'd0);
    check("mrst_head_valid",  32'(head_valid),   32'd0);
    check("mrst_head_y",      head_y,            32'd0);
    check("mrst_spawn_ready", 32'(spawn_ready),  32'd1);
    check("mrst_overrun",     32'(tick_overrun), 32'd0);
    check("mrst_miss_count",  32'(miss_count),   32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("mrst_rel_spawn_ready", 32'(spawn_ready), 32'd1);
    check("mrst_rel_count",       32'(count),       32'd0);

    spawn_valid = 1'b1;
    @(negedge clock);
    spawn_valid = 1'b0;
    frame_pulse();
    repeat (9) @(negedge clock);
    check("mrst_after_head_y", head_y,         32'd2);
    check("mrst_after_ready",  32'(hit_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/note_lane_scroller.md
# note_lane_scroller

Producer side of the note/bar hit check: owns the falling notes of one guitar lane, spawns them at the top of the screen, advances their y position once per video frame, and presents the oldest note's y to the downstream intersect comparator. The comparator's result drives `hit_pop`; notes that scroll past the bottom are retired as misses. One instance sits per lane, between the chart sequencer and the scoring/VGA logic.

## Interface
- `SLOTS`, 8: note buffer depth; must be a power of two.
- `SCREEN_H`, 480: y value at which a note is off-screen.
- `SPEED`, 2: pixels added to every live note per frame; range 1..15.
- `clock`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous and active-low.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `spawn_valid`  in  1  chart sequencer requests a new note.
- `spawn_ready`  out  1  spawn is accepted this cycle when both are high.
- `hit_pop`  in  1  scoring retires the head note as hit; accepted when `hit_ready` is high.
- `hit_ready`  out  1  high when the state is IDLE and count > 0.
- `head_valid`  out  1  buffer non-empty.
- `head_y`  out  32  y of the oldest note; zero-extended; 0 when empty.
- `rd_idx`  in  log2(SLOTS)  render read index, counted from head.
- `rd_valid`  out  1  rd_idx < count; combinational.
- `rd_y`  out  32  y of that note; 0 when `rd_valid` is low.
- `miss`  out  1  registered one-cycle pulse per auto-retired note.
- `count`  out  log2(SLOTS)+1  live notes.
- `tick_overrun`  out  1  sticky; set when a frame_tick is dropped.
- `miss_count`  out  16  see Configuration.

## Operation
- Storage: circular buffer of `SLOTS` y entries, each 10 bits wide, with head pointer, tail pointer and count. Outputs are zero-extended to 32 bits.
- The FSM has three states: IDLE, SWEEP, CHECK.
- **IDLE**
  - `spawn_ready` = (count < SLOTS).
  - An accepted spawn writes y = 0 at tail; tail and count increment.
  - An accepted `hit_pop` advances head and decrements count.
  - Spawn and pop in the same cycle both take effect; count is unchanged; with count == SLOTS, spawn_ready stays low.
  - `frame_tick`, or a pending tick, moves the FSM to SWEEP and sets slot index i = 0.
- **SWEEP**
  - Lasts exactly SLOTS cycles, one physical slot per cycle.
  - A live slot gets y = min(y + SPEED, 1023). The 11-bit sum saturates and never wraps.
  - Dead slots are untouched.
  - After slot SLOTS-1, go to CHECK.
- **CHECK**
  - If count > 0 and head_y >= SCREEN_H: pop the head, pulse `miss` next cycle, and stay in CHECK.
  - Otherwise return to IDLE.
- Outside IDLE, `spawn_ready` and `hit_ready` are 0 and `hit_pop` is ignored.
- Frame ticks outside IDLE:
  - The first `frame_tick` outside IDLE sets a one-deep pending flag.
  - Further ticks while pending is set are dropped and set `tick_overrun`.
- `hit_pop` when empty is ignored. Ordering (FIFO) is preserved, because notes only move together.

## Timing
- Reset values: state IDLE; head, tail, count, pending, `miss` and `tick_overrun` all 0; `head_valid` 0; `head_y` 0; `spawn_ready` 1; `hit_ready` 0; all slot y values 0.
- Reset asserted mid-SWEEP or mid-CHECK clears everything immediately. No partial update survives.
- Spawn is accepted at edge t: `head_valid`/`count` reflect it after edge t.
- `frame_tick` is sampled in IDLE at edge t:
  - SWEEP occupies edges t+1..t+SLOTS.
  - CHECK is at t+SLOTS+1.
  - IDLE resumes at t+SLOTS+2 when there is no retire; each retire adds one cycle.
- `head_y` is registered-path stable: it changes only at pop, spawn-into-empty, and sweep of the head slot.
- `miss` asserts the cycle after the retiring CHECK edge, for exactly one cycle per note.
- With `SLOTS`=8, frame-update occupancy is 10 cycles, far below one frame period.

## Configuration
- `MISS_COUNTER_EN`
  - When defined: `miss_count` is a 16-bit counter that increments on each `miss` pulse and saturates at 0xFFFF. It resets to 0.
  - When undefined: `miss_count` is tied to 0 and no counter logic is built.

## Test plan
Defaults: SLOTS=8, SCREEN_H=480, SPEED=2.
- Reset mid-SWEEP: all outputs return to reset values asynchronously; `spawn_ready`=1 on the first clock after release.
- Spawn 1 note, then 3 frame_ticks spaced 20 cycles apart: `head_y` = 0, 2, 4, 6; IDLE returns 10 cycles after each tick.
- Spawn 8 notes: 9th spawn_valid sees `spawn_ready`=0. Simultaneous spawn+hit_pop with count=7 leaves count=7; head advances.
- Spawn 1 note, then 240 ticks: on tick 240, y=480, CHECK retires it; `miss` pulses once; count=0; `miss_count`=1 with the macro, 0 without.
- Two ticks in the same SWEEP: the first is pending and serviced right after IDLE; the second sets `tick_overrun`=1.
- hit_pop with count=0, or during SWEEP: no state change; `hit_ready`=0 throughout.
